// File: rtl/aes_cudu_param.sv
// aes_cudu_param: iterative AES-128 encryptor computing RPC rounds per clock with on-the-fly key expansion.
// Optional CBC chaining (iv/iv_load ports, chain register) is enabled by defining AES_CBC_EN.
module aes_cudu_param #(
  parameter int RPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  input  logic [127:0] plaintext,
`ifdef AES_CBC_EN
  input  logic [127:0] iv,
  input  logic         iv_load,
`endif
  output logic [127:0] cipher,
  output logic         busy,
  output logic         done
);

  localparam int         NCYC     = 10 / RPC;
  localparam logic [3:0] RPC_INC  = 4'(RPC);
  localparam logic [3:0] LAST_CTR = 4'(1 + (NCYC - 1) * RPC);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  if (!(RPC == 1 || RPC == 2 || RPC == 5 || RPC == 10)) begin : g_bad_rpc
    $error("aes_cudu_param: RPC must be 1, 2, 5 or 10");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] idx;
    idx = 11'd2047 - {b, 3'b000};
    return SBOX[idx -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rn);
    logic [7:0] rc;
    case (rn)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Byte i of the state is row i%4, column i/4; ShiftRows rotates row r left by r columns.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] sb, sr, mc;
    for (int i = 0; i < 16; i++) begin
      sb[127 - 8*i -: 8] = sbox(s[127 - 8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127 - 8*(4*c + r) -: 8] = sb[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127 - 32*c -: 32] = mix_col(sr[127 - 32*c -: 32]);
    end
    return (last ? sr : mc) ^ rk;
  endfunction

  logic [0:0]   fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_ctr_q, round_ctr_d;
  logic [127:0] cipher_q, cipher_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [127:0] rnd_state_s, rnd_key_s, blk_in_s;
  logic [3:0]   rnd_num_s;
`ifdef AES_CBC_EN
  logic [127:0] chain_q, chain_d;
`endif

  // Unrolled RPC rounds for the current cycle; the round number picks Rcon and the last-round bypass.
  always_comb begin
    rnd_state_s = state_q;
    rnd_key_s   = rkey_q;
    rnd_num_s   = round_ctr_q;
    for (int i = 0; i < RPC; i++) begin
      rnd_num_s   = round_ctr_q + 4'(i);
      rnd_key_s   = key_next(rnd_key_s, rcon(rnd_num_s));
      rnd_state_s = aes_round(rnd_state_s, rnd_key_s, rnd_num_s == 4'd10);
    end
  end

  // Control FSM and next-state selection for all architectural registers.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    rkey_d      = rkey_q;
    round_ctr_d = round_ctr_q;
    cipher_d    = cipher_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
`ifdef AES_CBC_EN
    chain_d = chain_q;
    if (iv_load) begin
      blk_in_s = plaintext ^ iv;
    end else begin
      blk_in_s = plaintext ^ chain_q;
    end
`else
    blk_in_s = plaintext;
`endif
    case (fsm_q)
      ST_IDLE: begin
`ifdef AES_CBC_EN
        if (iv_load) begin
          chain_d = iv;
        end else begin
          chain_d = chain_q;
        end
`endif
        if (start) begin
          fsm_d       = ST_RUN;
          state_d     = blk_in_s ^ key;
          rkey_d      = key;
          round_ctr_d = 4'd1;
          busy_d      = 1'b1;
        end else begin
          fsm_d  = ST_IDLE;
          busy_d = 1'b0;
        end
      end
      ST_RUN: begin
        state_d     = rnd_state_s;
        rkey_d      = rnd_key_s;
        round_ctr_d = round_ctr_q + RPC_INC;
        if (round_ctr_q == LAST_CTR) begin
          fsm_d    = ST_IDLE;
          cipher_d = rnd_state_s;
          done_d   = 1'b1;
          busy_d   = 1'b0;
`ifdef AES_CBC_EN
          chain_d = rnd_state_s;
`endif
        end else begin
          fsm_d  = ST_RUN;
          busy_d = 1'b1;
        end
      end
      default: begin
        fsm_d  = ST_IDLE;
        busy_d = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= 128'd0;
      rkey_q      <= 128'd0;
      round_ctr_q <= 4'd0;
      cipher_q    <= 128'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef AES_CBC_EN
      chain_q     <= 128'd0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      rkey_q      <= rkey_d;
      round_ctr_q <= round_ctr_d;
      cipher_q    <= cipher_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef AES_CBC_EN
      chain_q     <= chain_d;
`endif
    end
  end

  assign cipher = cipher_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_aes_cudu_param.sv
// Randomised scoreboard bench for aes_cudu_param at RPC = 1, 2, 5, 10 against a table-free AES model.
// CBC scenarios are included when AES_CBC_EN is defined.
module tb_aes_cudu_param;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   start_s = 4'd0;
  logic [3:0]   ivl_s = 4'd0;
  logic [127:0] key_s = 128'd0;
  logic [127:0] pt_s = 128'd0;
  logic [127:0] iv_s = 128'd0;
  logic [127:0] ct_w [4];
  logic [3:0]   busy_w, done_w;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int nc [4] = '{10, 5, 2, 1};

  typedef struct {
    int           inst;
    logic [127:0] ct;
    int           due;
  } exp_t;
  exp_t sbq [$];

  logic [127:0] last_ct [4] = '{128'd0, 128'd0, 128'd0, 128'd0};
  logic [127:0] m_chain [4] = '{128'd0, 128'd0, 128'd0, 128'd0};
  logic [7:0]   sb [256];

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PA = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PB = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CA = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] CB = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] IV = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CBC_A = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CBC_B = 128'h5086cb9b507219ee95db113a917678b2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int RPC_G = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 5 : 10;
    aes_cudu_param #(.RPC(RPC_G)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_s[g]),
      .key       (key_s),
      .plaintext (pt_s),
`ifdef AES_CBC_EN
      .iv        (iv_s),
      .iv_load   (ivl_s[g]),
`endif
      .cipher    (ct_w[g]),
      .busy      (busy_w[g]),
      .done      (done_w[g])
    );

    always @(negedge clk) begin
      if (done_w[g]) check_done(g);
      else chk($sformatf("cipher_hold inst%0d", g), ct_w[g], last_ct[g]);
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_done(input int g);
    int idx;
    idx = -1;
    for (int i = 0; i < sbq.size(); i++) if (idx < 0 && sbq[i].inst == g) idx = i;
    if (idx < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_unexpected inst%0d at cycle %0d: got done=1 expected done=0", g, cyc);
    end else begin
      chk($sformatf("cipher inst%0d", g), ct_w[g], sbq[idx].ct);
      chk($sformatf("latency inst%0d", g), 128'(cyc), 128'(sbq[idx].due));
      last_ct[g] = sbq[idx].ct;
      sbq.delete(idx);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference AES-128: full key schedule first, then ten rounds on a byte array.
  function automatic logic [127:0] model_enc(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] o;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ k[127 - 8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[4*c + j] = t[4*((c + j) % 4) + j];
      if (r < 10) begin
        for (int c = 0; c < 4; c++)
          for (int j = 0; j < 4; j++)
            t[4*c + j] = gmul(8'h02, s[4*c + j]) ^ gmul(8'h03, s[4*c + (j + 1) % 4])
                       ^ s[4*c + (j + 2) % 4] ^ s[4*c + (j + 3) % 4];
        for (int i = 0; i < 16; i++) s[i] = t[i];
      end
      for (int c = 0; c < 4; c++)
        for (int j = 0; j < 4; j++) s[4*c + j] = s[4*c + j] ^ w[4*r + c][31 - 8*j -: 8];
    end
    for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic launch(input int g, input logic [127:0] k, input logic [127:0] p, input bit ld,
                        input logic [127:0] ivv, input bit use_kat, input logic [127:0] kat,
                        input bit hold);
    logic [127:0] e;
    key_s = k;
    pt_s  = p;
    if (ld) begin
      iv_s       = ivv;
      ivl_s[g]   = 1'b1;
      m_chain[g] = ivv;
    end
    start_s[g] = 1'b1;
`ifdef AES_CBC_EN
    e = model_enc(k, p ^ m_chain[g]);
`else
    e = model_enc(k, p);
`endif
    if (use_kat) e = kat;
    m_chain[g] = e;
    sbq.push_back('{inst: g, ct: e, due: cyc + 1 + nc[g]});
    @(negedge clk);
    if (!hold) start_s[g] = 1'b0;
    ivl_s[g] = 1'b0;
  endtask

  task automatic idle_wait(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      if (!start_s[g]) begin
        key_s = rnd128();
        pt_s  = rnd128();
      end
      @(negedge clk);
    end
  endtask

  task automatic issue_blk(input int g, input logic [127:0] k, input logic [127:0] p, input bit ld,
                           input logic [127:0] ivv, input bit use_kat, input logic [127:0] kat);
    launch(g, k, p, ld, ivv, use_kat, kat, 1'b0);
    idle_wait(g, nc[g]);
  endtask

  task automatic held_run(input int g, input int nblk);
    for (int b = 0; b < nblk; b++) begin
      launch(g, rnd128(), rnd128(), 1'b0, 128'd0, 1'b0, 128'd0, b < nblk - 1);
      idle_wait(g, nc[g]);
    end
  endtask

  initial begin
    logic [7:0] inv, x8, y8;
    #1 rst = 1'b0;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      x8  = 8'(x);
      for (int y = 1; y < 256; y++) begin
        y8 = 8'(y);
        if (gmul(x8, y8) == 8'h01) inv = y8;
      end
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("reset_busy inst%0d", g), 128'(busy_w[g]), 128'd0);
      chk($sformatf("reset_done inst%0d", g), 128'(done_w[g]), 128'd0);
      chk($sformatf("reset_cipher inst%0d", g), ct_w[g], 128'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    issue_blk(0, K1, P1, 1'b1, 128'd0, 1'b1, C1);
    for (int g = 0; g < 4; g++) begin
      issue_blk(g, K2, PA, 1'b1, 128'd0, 1'b1, CA);
      issue_blk(g, K2, PB, 1'b1, 128'd0, 1'b1, CB);
    end

    launch(0, rnd128(), rnd128(), 1'b0, 128'd0, 1'b0, 128'd0, 1'b0);
    idle_wait(0, 3);
    chk("busy_mid_block", 128'(busy_w[0]), 128'd1);
    key_s = rnd128();
    pt_s  = rnd128();
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    idle_wait(0, nc[0] - 4);
    held_run(0, 3);
    held_run(2, 3);
    held_run(3, 3);

    launch(0, K1, P1, 1'b1, 128'd0, 1'b1, C1, 1'b0);
    idle_wait(0, 4);
    #2;
    rst = 1'b0;
    sbq.delete();
    for (int g = 0; g < 4; g++) begin
      last_ct[g] = 128'd0;
      m_chain[g] = 128'd0;
    end
    @(negedge clk);
    chk("abort_busy", 128'(busy_w[0]), 128'd0);
    chk("abort_cipher", ct_w[0], 128'd0);
    chk("abort_done", 128'(done_w[0]), 128'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_wait(0, 3);
    issue_blk(0, K1, P1, 1'b1, 128'd0, 1'b1, C1);

`ifdef AES_CBC_EN
    issue_blk(0, K2, PA, 1'b1, IV, 1'b1, CBC_A);
    issue_blk(0, K2, PB, 1'b0, 128'd0, 1'b1, CBC_B);
    launch(1, K2, PA, 1'b1, IV, 1'b1, CBC_A, 1'b0);
    idle_wait(1, 2);
    iv_s     = rnd128();
    ivl_s[1] = 1'b1;
    @(negedge clk);
    ivl_s[1] = 1'b0;
    idle_wait(1, nc[1] - 3);
    issue_blk(1, K2, PB, 1'b0, 128'd0, 1'b1, CBC_B);
`endif

    for (int n = 0; n < 24; n++) begin
      issue_blk($urandom_range(0, 3), rnd128(), rnd128(), ($urandom_range(0, 3) == 0),
                rnd128(), 1'b0, 128'd0);
    end

    idle_wait(0, 5);
    chk("pending_expected", 128'(sbq.size()), 128'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_cudu_param.md
Name: aes_cudu_param

Overview:
Parametrised successor to the fixed AES-128 control/datapath core: iterative FIPS-197 AES-128 encryption with a run-time key input and an explicit start/busy/done handshake. The number of rounds computed per clock is set by `RPC`, trading area for latency. Key expansion is done on the fly, so no round-key RAM is needed. The block sits between the plaintext source and the ciphertext consumer, and the top level drives it as a single-block-at-a-time engine.

Parameters:
- `RPC`, default 1: rounds per clock. Legal values are 1, 2, 5 and 10; any other value is a compile-time `$error`.
- `NCYC`, derived as 10/`RPC`, not overridable: number of round cycles per block.

Ports:
- `clk`  input  1  single clock; all flops are rising-edge.
- `rst`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only when `busy`=0.
- `key`  input  128  cipher key; captured on an accepted `start`.
- `plaintext`  input  128  input block; captured on an accepted `start`.
- `cipher`  output  128  ciphertext; registered, holds until the next `done`.
- `busy`  output  1  high while a block is in flight.
- `done`  output  1  one-cycle pulse; `cipher` is valid in the same cycle.
- `iv`  input  128  CBC initial vector. Present only with `AES_CBC_EN`.
- `iv_load`  input  1  loads the chaining register from `iv`. Present only with `AES_CBC_EN`.

Behaviour:
- Reset (`rst`=0, asynchronous): FSM goes to IDLE; `state`, `rkey`, `round_ctr`, `cipher` and the chain register clear to 0; `busy`=0, `done`=0.
- Reset asserted mid-block: the block is aborted and no `done` is produced.
- FSM states are IDLE and RUN.
- IDLE -> RUN on `start`=1 at a rising edge. At that edge:
  - `state` <= `blk_in` ^ `key`
  - `rkey` <= `key`
  - `round_ctr` <= 1
  - `busy` <= 1
- `blk_in` is `plaintext` in ECB, or `plaintext` ^ `chain` under `AES_CBC_EN`.
- RUN: each cycle applies `RPC` consecutive rounds combinationally. Each round is:
  - SubBytes, ShiftRows, MixColumns (MixColumns omitted in round 10), AddRoundKey.
  - The round key is derived from the previous one through RotWord/SubWord/Rcon.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36, indexed by round number.
  - `round_ctr` advances by `RPC`.
- When the cycle containing round 10 completes:
  - `cipher` <= result, `done` <= 1, `busy` <= 0, FSM -> IDLE.
  - The chain register is updated under `AES_CBC_EN`.
- Latency: `start` accepted at edge N gives `done`=1 and a valid `cipher` after edge N+`NCYC`. That is 10 cycles at `RPC`=1 and 1 cycle at `RPC`=10.
- Throughput: one block per `NCYC`+1 cycles.
- `start` while `busy`=1 is ignored. There is no queueing.
- `start` in the same cycle as `done`=1: accepted, because `busy` is already 0. This gives back-to-back blocks with no bubble beyond the IDLE cycle.
- `key` and `plaintext` may change freely while `busy`; only the values captured at the accepted `start` are used.
- `cipher` is never modified except at a `done` edge.
- Arithmetic: all GF(2^8) multiplies are xtime-based with reduction polynomial 0x11b. Byte order is big-endian: byte 0 is [127:120], and the state is column-major per FIPS-197.

Optional Feature:
- Macro `AES_CBC_EN`.
- Defined:
  - Adds the `iv` and `iv_load` ports and a 128-bit `chain` register.
  - `iv_load`=1 at an edge with `busy`=0 sets `chain` <= `iv`.
  - If `iv_load` and `start` are asserted in the same cycle, the newly loaded `iv` is used for that block.
  - Each `done` sets `chain` <= `cipher`.
  - `iv_load` while `busy` is ignored.
- Undefined:
  - Pure ECB; the ports and the `chain` register do not exist.

Test Plan:
1. FIPS-197 C.1, `RPC`=1: `key`=000102030405060708090a0b0c0d0e0f, `plaintext`=00112233445566778899aabbccddeeff, `start` pulse -> `done` exactly 10 cycles later, `cipher`=69c4e0d86a7b0430d8cdb78070b4c55a.
2. SP800-38A ECB, `RPC` in {1,2,5,10}: `key`=2b7e151628aed2a6abf7158809cf4f3c, `plaintext`=6bc1bee22e409f96e93d7e117393172a -> `cipher`=3ad77bb40d7a3660a89ecaf32466ef97.
   - Then `plaintext`=ae2d8a571e03ac9c9eb76fac45af8e51 -> `cipher`=f5d3d58503b9699de785895a96fdbaaf.
   - `done` latency is 10/5/2/1 cycles respectively.
3. Handshake: second `start` while `busy` -> ignored, with exactly one `done`. `start` held high through `done` -> the next block starts with a 1-cycle IDLE gap, and `cipher` holds between `done`s.
4. Reset mid-block: drop `rst` at round 5 -> `busy`=0, `cipher`=0, no `done`. After release, vector 1 completes correctly.
5. `AES_CBC_EN`: `iv`=000102030405060708090a0b0c0d0e0f loaded, same key as scenario 2, two chained blocks 6bc1...172a then ae2d...8e51 -> `cipher`=7649abac8119b246cee98e9b12e9197d, then 5086cb9b507219ee95db113a917678b2.
6. `AES_CBC_EN`: `iv_load` pulse during `busy` -> ignored. The current block and its chain update are unchanged.
